// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, address regions,
// I/O register offsets and the fault read-back word.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_BAD
    } region_e;

    localparam logic [31:0] IO_LED_OFS = 32'd0;
    localparam logic [31:0] IO_SW_OFS  = 32'd4;
    localparam logic [31:0] IO_CNT_OFS = 32'd8;
    localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;

    // Misaligned addresses fault even when they fall inside RAM or the I/O window.
    function automatic region_e decode_region(
        input logic [31:0] adr,
        input int unsigned depth_words,
        input logic [31:0] io_base
    );
        region_e r;
        r = REG_BAD;
        if (adr[1:0] == 2'b00) begin
            if (adr < 32'(depth_words * 4)) begin
                r = REG_RAM;
            end else if ((adr == io_base + IO_LED_OFS) ||
                         (adr == io_base + IO_SW_OFS)  ||
                         (adr == io_base + IO_CNT_OFS)) begin
                r = REG_IO;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bundle: address/data/strobes from the CPU, load data and ready/error back.
interface dmem_responder_if;

    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;

    modport master (
        output DataAdr, WriteData, MemWrite, MemRead,
        input  ReadData, MemReady, MemErr
    );

    modport slave (
        input  DataAdr, WriteData, MemWrite, MemRead,
        output ReadData, MemReady, MemErr
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-organised RAM with synchronous write and a registered read port; contents are not reset.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 64,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-port slave serving a word RAM plus LED/switch/cycle-counter I/O with WAIT_STATES latency.
// Define DMEM_TRACE_EN to print one simulation line per response.
//   state | meaning
//   IDLE  | waiting for MemRead/MemWrite; request captured on the edge it is seen
//   WAIT  | counting down wait states on the latched request
//   RESP  | MemReady (and MemErr on fault) high for one cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'h0000_0400
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic [7:0]      io_out,
    input  logic [7:0]      io_in
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        sel_ram_q, sel_ram_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] cyc_q, cyc_d;
    logic [7:0]  sync1_q, sync2_q;

    logic          req;
    logic          go_resp;
    logic [31:0]   eff_adr;
    logic [31:0]   eff_wdata;
    logic          eff_wr;
    logic [31:0]   io_ofs;
    region_e       eff_reg;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rdata;

    // With zero wait states the response is committed on the capture edge itself, so decode
    // looks at the live bus in IDLE and at the latched request otherwise.
    always_comb begin
        req = bus.MemWrite | bus.MemRead;
        if (state_q == IDLE) begin
            eff_adr   = bus.DataAdr;
            eff_wdata = bus.WriteData;
            eff_wr    = bus.MemWrite;
        end else begin
            eff_adr   = adr_q;
            eff_wdata = wdata_q;
            eff_wr    = wr_q;
        end
        eff_reg = decode_region(eff_adr, DEPTH_WORDS, IO_BASE);
        io_ofs  = eff_adr - IO_BASE;
        ram_idx = eff_adr[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d   = bus.DataAdr;
                    wdata_d = bus.WriteData;
                    wr_d    = bus.MemWrite;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_we    = go_resp && eff_wr && (eff_reg == REG_RAM);
        ram_re    = go_resp && !eff_wr && (eff_reg == REG_RAM);
        led_d     = led_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        sel_ram_d = sel_ram_q;
        cyc_d     = cyc_q + 32'd1;
        if (go_resp) begin
            err_d     = (eff_reg == REG_BAD);
            sel_ram_d = (eff_reg == REG_RAM) && !eff_wr;
            rdata_d   = '0;
            case (eff_reg)
                REG_BAD: begin
                    rdata_d = ERR_WORD;
                end
                REG_IO: begin
                    if (io_ofs == IO_LED_OFS) begin
                        if (eff_wr) begin
                            led_d = eff_wdata[7:0];
                        end else begin
                            rdata_d = {24'h0, led_q};
                        end
                    end else if (io_ofs == IO_SW_OFS) begin
                        if (!eff_wr) begin
                            rdata_d = {24'h0, sync2_q};
                        end
                    end else if (!eff_wr) begin
                        rdata_d = cyc_q;
                    end
                end
                default: begin
                    rdata_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            sel_ram_q <= 1'b0;
            led_q     <= '0;
            cyc_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            sel_ram_q <= sel_ram_d;
            led_q     <= led_d;
            cyc_q     <= cyc_d;
            sync1_q   <= io_in;
            sync2_q   <= sync1_q;
        end
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    // RAM loads come straight from the RAM's own output register, which only reloads on RAM reads.
    assign bus.ReadData = sel_ram_q ? ram_rdata : rdata_q;
    assign bus.MemReady = (state_q == RESP);
    assign bus.MemErr   = (state_q == RESP) && err_q;
    assign io_out       = led_q;

`ifdef DMEM_TRACE_EN
    always @(posedge clk) begin
        if (state_q == RESP) begin
            $display("%0t dmem %s adr=%h data=%h err=%0d", $time, wr_q ? "W" : "R",
                     adr_q, wr_q ? wdata_q : bus.ReadData, err_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder: one instance with one wait state, one with none.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] IOB   = 32'h0000_0400;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] io_out1, io_out0;
    logic [7:0] io_in1, io_in0;

    dmem_responder_if bus1 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .IO_BASE(IOB)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .io_out(io_out1), .io_in(io_in1));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .IO_BASE(IOB)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .io_out(io_out0), .io_in(io_in0));

    int unsigned npass = 0;
    int unsigned nchk  = 0;
    int unsigned tb_cyc = 0;
    int unsigned last_t = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Reference model: plain array per instance plus LED and switch values.
    logic [31:0] mem_m [2][DEPTH];
    logic [7:0]  led_m [2];
    logic [7:0]  sw_m  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int w, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        if (w == 1) begin
            bus1.MemRead = rd; bus1.MemWrite = wr; bus1.DataAdr = a; bus1.WriteData = d;
        end else begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.DataAdr = a; bus0.WriteData = d;
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? bus1.MemReady : bus0.MemReady;
    endfunction

    function automatic logic [31:0] rdat(input int w);
        return (w == 1) ? bus1.ReadData : bus0.ReadData;
    endfunction

    function automatic logic errf(input int w);
        return (w == 1) ? bus1.MemErr : bus0.MemErr;
    endfunction

    function automatic logic [7:0] ioo(input int w);
        return (w == 1) ? io_out1 : io_out0;
    endfunction

    task automatic access(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        logic got;
        got = 1'b0;
        rd  = 'x;
        er  = 1'bx;
        lat = 0;
        drive(w, !wr, wr, a, d);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy(w) === 1'b1) begin
                got    = 1'b1;
                rd     = rdat(w);
                er     = errf(w);
                last_t = tb_cyc;
            end
        end
        drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ready_seen", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        check("ready_width", {31'b0, rdy(w)}, 32'd0);
    endtask

    // Expected outcome from the address map rules; known=0 where read data is not predicted.
    task automatic model_op(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output logic exp_err, output logic known);
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        known   = 1'b1;
        if (a[1:0] != 2'b00 ||
            !(a < 32'(DEPTH * 4) || a == IOB || a == IOB + 32'd4 || a == IOB + 32'd8)) begin
            exp_err = 1'b1;
            exp_rd  = 32'hDEAD_BEEF;
        end else if (a < 32'(DEPTH * 4)) begin
            if (wr) begin mem_m[w][a / 4] = d; known = 1'b0; end
            else exp_rd = mem_m[w][a / 4];
        end else if (a == IOB) begin
            if (wr) begin led_m[w] = d[7:0]; known = 1'b0; end
            else exp_rd = {24'h0, led_m[w]};
        end else if (a == IOB + 32'd4) begin
            if (wr) known = 1'b0;
            else exp_rd = {24'h0, sw_m[w]};
        end else begin
            known = 1'b0;
        end
    endtask

    task automatic do_op(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
        logic [31:0] exp_rd, rd;
        logic        exp_err, known, er;
        int          lat;
        model_op(w, wr, a, d, exp_rd, exp_err, known);
        access(w, wr, a, d, rd, er, lat);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        if (known) check({tag, "_data"}, rd, exp_rd);
        check({tag, "_lat"}, lat, (w == 1) ? 32'd2 : 32'd1);
        check({tag, "_io_out"}, {24'h0, ioo(w)}, {24'h0, led_m[w]});
    endtask

    initial begin
        logic [31:0] r1, r2, a, d;
        logic        e1, e2, got;
        int          lat;
        int unsigned t1, t2, k;
        logic [31:0] pre20;

        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        io_in1 = 8'h00; io_in0 = 8'h00;
        for (int w = 0; w < 2; w++) begin led_m[w] = 8'h00; sw_m[w] = 8'h00; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", bus1.ReadData, 32'h0);
        check("rst_ready", {31'b0, bus1.MemReady}, 32'h0);
        check("rst_err", {31'b0, bus1.MemErr}, 32'h0);
        check("rst_io_out", {24'h0, io_out1}, 32'h0);
        check("rst_ready0", {31'b0, bus0.MemReady}, 32'h0);
        @(negedge clk) reset = 1'b1;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < int'(DEPTH); i++)
                do_op(w, 1'b1, 32'(i * 4), $urandom, "fill");

        do_op(1, 1'b1, 32'h10, 32'h0000_00AA, "w10");
        do_op(1, 1'b0, 32'h10, 32'h0, "r10");

        // Zero-wait instance: strobe held across two reads, one access every two cycles.
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (bus0.MemReady === 1'b1) got = 1'b1;
        end
        check("b2b_first", {31'b0, got}, 32'd1);
        check("b2b_rd0", bus0.ReadData, mem_m[0][0]);
        bus0.DataAdr = 32'h4;
        @(posedge clk); #1;
        check("b2b_gap", {31'b0, bus0.MemReady}, 32'd0);
        @(posedge clk); #1;
        check("b2b_second", {31'b0, bus0.MemReady}, 32'd1);
        check("b2b_rd1", bus0.ReadData, mem_m[0][1]);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("b2b_width", {31'b0, bus0.MemReady}, 32'd0);

        do_op(1, 1'b1, IOB, 32'h1234_5681, "wled");
        do_op(1, 1'b0, IOB, 32'h0, "rled");
        do_op(1, 1'b1, IOB + 32'd4, 32'hFFFF_FFFF, "wsw");

        do_op(1, 1'b1, 32'h2, 32'h5555_AAAA, "wmis");
        do_op(1, 1'b0, 32'h2, 32'h0, "rmis");
        do_op(1, 1'b0, 32'h0, 32'h0, "r0_after_mis");
        do_op(1, 1'b0, 32'h300, 32'h0, "rhole");
        do_op(1, 1'b0, 32'(DEPTH * 4), 32'h0, "rpastram");
        do_op(1, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, "rlastram");
        do_op(1, 1'b0, IOB + 32'd12, 32'h0, "rpastio");

        io_in1 = 8'h5A; sw_m[1] = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        do_op(1, 1'b0, IOB + 32'd4, 32'h0, "rsw");

        for (int n = 0; n < 3; n++) begin
            access(1, 1'b0, IOB + 32'd8, 32'h0, r1, e1, lat);
            t1 = last_t;
            repeat ($urandom_range(0, 6)) @(posedge clk);
            access(1, 1'b0, IOB + 32'd8, 32'h0, r2, e2, lat);
            t2 = last_t;
            check("cnt_delta", r2 - r1, t2 - t1);
            check("cnt_err", {30'b0, e1, e2}, 32'h0);
        end

        // Reset in the wait state of a write: nothing is committed.
        pre20 = mem_m[1][8];
        check("pre_rst_led", {24'h0, io_out1}, 32'h81);
        drive(1, 1'b0, 1'b1, 32'h20, ~pre20);
        @(posedge clk); #1;
        check("rst_wait_ready", {31'b0, bus1.MemReady}, 32'h0);
        reset = 1'b0;
        #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst_mid_ready", {31'b0, bus1.MemReady}, 32'h0);
        check("rst_mid_io_out", {24'h0, io_out1}, 32'h0);
        led_m[0] = 8'h00; led_m[1] = 8'h00;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'b0, bus1.MemReady}, 32'h0);
        do_op(1, 1'b0, 32'h20, 32'h0, "r20_after_rst");
        check("r20_model", mem_m[1][8], pre20);

        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 60; n++) begin
                if (n % 15 == 0) begin
                    sw_m[w] = 8'($urandom);
                    if (w == 1) io_in1 = sw_m[w]; else io_in0 = sw_m[w];
                    repeat (3) @(posedge clk);
                    #1;
                end
                k = $urandom_range(0, 7);
                d = $urandom;
                case (k)
                    0, 1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1) * 4);
                    4: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                    5: a = IOB;
                    6: a = IOB + 32'd4;
                    default: a = ($urandom_range(0, 1) == 1) ? IOB + 32'd12
                                 : 32'(DEPTH * 4 + $urandom_range(0, 191) * 4);
                endcase
                do_op(w, 1'($urandom_range(0, 1)), a, d, "rand");
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the CPU data port: the slave end of the DataAdr/WriteData/MemWrite/ReadData interface. Adds a read strobe and a ready/error handshake. Serves a word-addressed RAM plus a small memory-mapped I/O window (LED register, switch input, cycle counter). Has a configurable wait-state count, so the CPU is verified against a non-zero-latency memory.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1
WAIT_STATES, 1, extra cycles between request capture and response, range 0..15
IO_BASE, 32'h0000_0400, byte base address of the I/O window; must lie above the RAM

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
DataAdr  in  32  byte address from CPU
WriteData  in  32  store data from CPU
MemWrite  in  1  write request
MemRead  in  1  read request
ReadData  out  32  load data, valid while MemReady=1
MemReady  out  1  one-cycle response strobe
MemErr  out  1  qualifies MemReady: access faulted
io_out  out  8  LED register
io_in  in  8  asynchronous switch inputs

Behaviour:
- Reset (reset=0, async): FSM=IDLE, wait counter=0. ReadData=0, MemReady=0, MemErr=0, io_out=0, cycle counter=0, io_in synchroniser=0. RAM contents are not cleared. Any pending access is dropped and a pending write is never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on an edge with MemWrite|MemRead, latch address, data and type. If both strobes are high, treat as a write. Go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
- WAIT: decrement the counter each edge; go to RESP after the edge where the counter reaches 0.
- RESP: MemReady=1 for exactly one cycle, then IDLE.
- Latency: request sampled at edge N gives MemReady high in the cycle after edge N+WAIT_STATES.
- Requests are ignored outside IDLE. The CPU holds its signals until MemReady. Maximum throughput is one access per WAIT_STATES+2 cycles.
- Writes commit to RAM or io_out on the edge entering RESP.
- ReadData is registered on the edge entering RESP. It holds until the next response.
- Address decode uses the latched address:
  - RAM: word index = addr[$clog2(DEPTH_WORDS)+1:2].
  - IO_BASE+0: io_out, read/write; reads are zero-extended, writes take bits [7:0].
  - IO_BASE+4: synchronised io_in, read-only; writes are silently ignored (no error).
  - IO_BASE+8: 32-bit free-running cycle counter, read-only; increments every clk and wraps 32'hFFFF_FFFF to 0.
- Fault: addr[1:0]!=0, or an address outside both RAM and the I/O window, gives MemErr=1 with MemReady. No state is written and ReadData=ERR_WORD (32'hDEAD_BEEF).
- io_in passes through a 2-flop synchroniser. A read returns the value 2 edges stale at most.
- Reset deasserting mid-sequence: the FSM starts in IDLE on the first edge after release.

Optional Feature:
DMEM_TRACE_EN
- Defined: on each RESP cycle, simulation-only $display of time, R/W, address, data and ERR flag. The display is outside synthesis paths.
- Undefined: no trace code is compiled.
- RTL behaviour is identical either way.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/WAIT/RESP)
  - I/O offsets IO_LED_OFS=0, IO_SW_OFS=4, IO_CNT_OFS=8
  - ERR_WORD=32'hDEAD_BEEF
  - region enum (REG_RAM/REG_IO/REG_BAD)
- Sub-module dmem_ram: synchronous-write, registered-read word array, parameterised by DEPTH_WORDS. The FSM, decode, I/O registers and counter stay in the top.

Test Plan:
- WAIT_STATES=1: write 32'h0000_00AA to 0x10, then read 0x10 -> MemReady pulses 2 cycles after each capture; read returns 32'h0000_00AA, MemErr=0.
- WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 with held strobes -> one access every 2 cycles; MemReady is one cycle wide each time.
- Write 32'h1234_5681 to IO_BASE -> io_out=8'h81 after RESP. Read IO_BASE -> 32'h0000_0081. Write to IO_BASE+4 -> no change, MemErr=0.
- Read 0x2 (misaligned) and 0x300 (hole) -> MemErr=1, ReadData=32'hDEAD_BEEF. Prior write to 0x2 leaves RAM unchanged.
- Drive io_in=8'h5A, read IO_BASE+4 three or more cycles later -> 32'h0000_005A. Two reads of IO_BASE+8 differ by exactly the number of cycles between their RESP edges.
- Assert reset during WAIT of a write to 0x20 -> MemReady stays 0, io_out=0, and a later read of 0x20 returns the pre-write value.
